// File: rtl/eth_phy_ipg_tx_insert.sv
`default_nettype none
// ============================================================================
// Module   : eth_phy_ipg_tx_insert
// Purpose  : 10G TX PHY inter-packet-gap message inserter. Sits between the
//            64b/66b encoder and the scrambler. Short side-channel messages
//            are buffered and substituted into idle control blocks inside
//            the inter-packet gap as custom IPG control blocks. All other
//            traffic passes through with a fixed one-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module eth_phy_ipg_tx_insert #(
    parameter int             DATA_WIDTH     = 64,
    parameter int             HDR_WIDTH      = 2,
    parameter logic [7:0]     IPG_BLOCK_TYPE = 8'h11,
    parameter int             FIFO_DEPTH     = 4,
    parameter int             MIN_IDLE_RUN   = 2
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] encoded_tx_data,
    input  logic [HDR_WIDTH-1:0]  encoded_tx_hdr,
    output logic [DATA_WIDTH-1:0] serdes_tx_data,
    output logic [HDR_WIDTH-1:0]  serdes_tx_hdr,

    input  logic                  tx_ipg_enable,
    input  logic [47:0]           ipg_tx_data,
    input  logic [5:0]            ipg_tx_len,
    input  logic                  ipg_tx_valid,
    output logic                  ipg_tx_ready,

    output logic [15:0]           ipg_insert_count,
    output logic [15:0]           ipg_drop_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                    c_ptr_w      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                    c_cnt_w      = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0]    c_depth      = c_cnt_w'(FIFO_DEPTH);
    localparam logic [3:0]            c_min_idle   = 4'(MIN_IDLE_RUN);
    localparam logic [DATA_WIDTH-1:0] c_idle_block = 64'h000000000000001E;
    localparam logic [HDR_WIDTH-1:0]  c_hdr_ctrl   = 2'b10;
    localparam logic [5:0]            c_max_len    = 6'd6;

    // ------------------------------------------------------------------------
    // Message buffer storage and bookkeeping
    // ------------------------------------------------------------------------
    logic [47:0]        r_fifo_data [FIFO_DEPTH];
    logic [5:0]         r_fifo_len  [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic [3:0]         r_idle_run;
    logic [15:0]        r_insert_count;
    logic [15:0]        r_drop_count;

    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_accept;
    logic               w_len_legal;
    logic               w_push;
    logic               w_drop;
    logic               w_in_idle;
    logic               w_substitute;
    logic [47:0]        w_head_data;
    logic [5:0]         w_head_len;
    logic [47:0]        w_payload;
    logic [DATA_WIDTH-1:0] w_ipg_block;

    // ------------------------------------------------------------------------
    // Handshake and classification
    // ------------------------------------------------------------------------
    assign w_fifo_full  = (r_count == c_depth);
    assign w_fifo_empty = (r_count == '0);
    assign ipg_tx_ready = ~w_fifo_full;

    assign w_accept     = ipg_tx_valid & ipg_tx_ready;
    assign w_len_legal  = (ipg_tx_len != 6'd0) && (ipg_tx_len <= c_max_len);
    assign w_push       = w_accept & w_len_legal;
    assign w_drop       = w_accept & ~w_len_legal;

    assign w_in_idle    = (encoded_tx_hdr == c_hdr_ctrl) && (encoded_tx_data == c_idle_block);

    // Only messages already stored at the start of the cycle are eligible;
    // the empty flag is registered state, so a same-cycle push cannot fall through.
    assign w_substitute = w_in_idle & tx_ipg_enable & ~w_fifo_empty &
                          (r_idle_run >= c_min_idle);

    // ------------------------------------------------------------------------
    // IPG block assembly from the buffer head
    // ------------------------------------------------------------------------
    assign w_head_data = r_fifo_data[r_rd_ptr];
    assign w_head_len  = r_fifo_len[r_rd_ptr];

    // Bytes beyond the message length are zeroed so stale payload never leaks.
    for (genvar i = 0; i < 6; i++) begin : g_mask
        assign w_payload[8*i +: 8] = (w_head_len > 6'(i)) ? w_head_data[8*i +: 8] : 8'h00;
    end

    assign w_ipg_block = {w_payload, 2'b00, w_head_len, IPG_BLOCK_TYPE};

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------

    // Buffer payload storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= ipg_tx_data;
            r_fifo_len[r_wr_ptr]  <= ipg_tx_len;
        end
    end

    // Buffer pointers and occupancy; push and pop together leave occupancy unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_substitute) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_push && !w_substitute) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (!w_push && w_substitute) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

    // Saturating count of consecutive idle inputs, including replaced ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle_run <= 4'd0;
        end else if (w_in_idle) begin
            if (r_idle_run != 4'hF) begin
                r_idle_run <= r_idle_run + 4'd1;
            end
        end else begin
            r_idle_run <= 4'd0;
        end
    end

    // Wrapping statistics counters for emitted IPG blocks and dropped messages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_insert_count <= 16'd0;
            r_drop_count   <= 16'd0;
        end else begin
            if (w_substitute) begin
                r_insert_count <= r_insert_count + 16'd1;
            end
            if (w_drop) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    // Registered output stage: replace the idle block or forward the input unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            serdes_tx_data <= c_idle_block;
            serdes_tx_hdr  <= c_hdr_ctrl;
        end else if (w_substitute) begin
            serdes_tx_data <= w_ipg_block;
            serdes_tx_hdr  <= c_hdr_ctrl;
        end else begin
            serdes_tx_data <= encoded_tx_data;
            serdes_tx_hdr  <= encoded_tx_hdr;
        end
    end

    assign ipg_insert_count = r_insert_count;
    assign ipg_drop_count   = r_drop_count;

endmodule
`default_nettype wire

// File: doc/eth_phy_ipg_tx_insert.md
Name: eth_phy_ipg_tx_insert

Overview:
Transmit-side counterpart of the receive-path IPG extraction (rx_len / rx_ipg_data). Sits between the 64b/66b encoder and the scrambler in the 10G TX PHY. Buffers short side-channel messages and substitutes them into idle control blocks in the inter-packet gap, as custom IPG control blocks. All non-idle traffic passes through unchanged with fixed latency.

Parameters:
DATA_WIDTH, 64, block payload width; only 64 is supported.
HDR_WIDTH, 2, sync header width; only 2 is supported.
IPG_BLOCK_TYPE, 8'h11, block-type byte marking an IPG data block.
FIFO_DEPTH, 4, message buffer depth; power of two, minimum 2.
MIN_IDLE_RUN, 2, number of consecutive idle blocks required before a substitution is allowed.

Ports:
clk  in  1  TX PCS clock.
rst  in  1  asynchronous active-high reset.
encoded_tx_data  in  64  block from the 64b/66b encoder.
encoded_tx_hdr  in  2  sync header from the encoder; 2'b01 = data, 2'b10 = control.
serdes_tx_data  out  64  block to the scrambler.
serdes_tx_hdr  out  2  sync header to the scrambler.
tx_ipg_enable  in  1  enables substitution.
ipg_tx_data  in  48  message payload; byte 0 = bits [7:0].
ipg_tx_len  in  6  number of valid payload bytes, legal range 1..6.
ipg_tx_valid  in  1  message offered.
ipg_tx_ready  out  1  buffer can accept a message.
ipg_insert_count  out  16  number of IPG blocks emitted; wraps.
ipg_drop_count  out  16  number of illegal-length messages discarded; wraps.

Behaviour:
- Reset (asynchronous, active-high):
  - serdes_tx_data = 64'h000000000000001E; serdes_tx_hdr = 2'b10.
  - FIFO empty; ipg_tx_ready = 1.
  - Both counters = 0; idle_run = 0.
- Idle block definition: hdr == 2'b10 and data == 64'h000000000000001E (type 0x1E, all eight control characters 0x00).
- Latency: output registered; every input block appears exactly 1 cycle later, replaced or unchanged.
- Message handshake:
  - Accept when ipg_tx_valid && ipg_tx_ready; ipg_tx_ready = !fifo_full.
  - Accepted message with len 0 or len > 6: not stored; ipg_drop_count += 1.
- idle_run:
  - 4-bit saturating (max 15) count of consecutive idle blocks immediately preceding the current input.
  - Incremented by idle inputs, including those that get replaced.
  - Cleared by any non-idle input.
- Substitution condition, evaluated on the current input: input is idle AND tx_ipg_enable AND FIFO non-empty at start of cycle AND idle_run >= MIN_IDLE_RUN.
- When substituting:
  - Output hdr = 2'b10.
  - Output data: [7:0] = IPG_BLOCK_TYPE; [13:8] = len; [15:14] = 0; [63:16] = payload.
  - Payload bytes at index >= len are forced to 0x00.
  - Pop the FIFO head; ipg_insert_count += 1.
- No fall-through: a message accepted in cycle N is eligible for substitution from cycle N+1 onward.
- Simultaneous push and pop in the same cycle is allowed; occupancy is unchanged.
- When full, ipg_tx_ready = 0, so no push occurs; a pop in that cycle makes ready 1 the following cycle.
- tx_ipg_enable low: data passes through; FIFO contents are retained and pushes still occur.
- Data blocks, start blocks, terminate blocks, and non-idle control blocks are never modified.
- Reset mid-stream: FIFO contents are discarded; output returns to the idle block immediately.

Test Plan:
- Reset, then 10 idle inputs with no message -> outputs are idle 1E/hdr 10 with 1-cycle latency; ipg_insert_count = 0.
- Push {data 48'h665544332211, len 6}, then feed idle, idle, idle -> first two outputs idle; third output 64'h665544332211_06_11 with hdr 10; ipg_insert_count = 1.
- Push len 3, payload 48'hFFFFFF_CCBBAA, into a long idle run -> output 64'h000000CCBBAA_03_11 (bytes 3-5 zeroed).
- Push len 0 and len 7 -> both accepted, none stored; ipg_drop_count = 2; no substitution occurs.
- Push 5 messages back-to-back with tx_ipg_enable = 0 -> ready deasserts after 4; enable during an idle run -> 4 consecutive IPG blocks emitted and ready reasserts.
- Frame stream (start 0x78, data, terminate 0x87, idle, data) with a pending message -> the idle after the terminate is not replaced (idle_run < 2); all frame blocks pass through bit-exact.
